// File: rtl/sar_result_averager.sv
// sar_result_averager: averages 2^LOG2_AVG SAR ADC results into a valid/ready
// output register, counting averages lost to back-pressure.
// Optional build macro: SAR_AVG_ROUND_EN (round-half-up instead of truncate).
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   clear         : flush accumulation and output register (keeps overrun/drop_count)
//   in_valid      : SAR valid level; a 0->1 transition marks a new result
//   in_result     : SAR result, sampled on the in_valid rising edge
//   out_data      : averaged result
//   out_valid     : out_data holds an unconsumed average
//   out_ready     : consumer accepts out_data on out_valid & out_ready
//   overrun       : sticky, a completed average was discarded
//   drop_count    : discarded averages, saturating at 255
//   fill          : samples accumulated in the current window
module sar_result_averager #(
    parameter int LOG2_AVG = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                in_valid,
    input  logic [7:0]          in_result,
    output logic [7:0]          out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                overrun,
    output logic [7:0]          drop_count,
    output logic [LOG2_AVG:0]   fill
);

    localparam int AW   = 8 + LOG2_AVG + 1;
    localparam int FW   = LOG2_AVG + 1;
    localparam int HALF = (2 ** LOG2_AVG) / 2;

    localparam logic [FW-1:0] LAST = FW'((2 ** LOG2_AVG) - 1);

    typedef enum logic {
        S_EMPTY,
        S_FULL
    } state_t;

    state_t        state;
    logic          prev;
    logic [AW-1:0] acc;
    logic [AW-1:0] sum;
    logic [AW-1:0] rounded;
    logic [AW-1:0] shifted;
    logic [7:0]    avg;
    logic          capture;
    logic          complete;

    assign capture  = in_valid & ~prev;
    assign complete = capture & (fill == LAST);
    assign sum      = acc + AW'(in_result);

`ifdef SAR_AVG_ROUND_EN
    // HALF is 0 for LOG2_AVG=0, so pass-through stays exact.
    assign rounded = sum + AW'(HALF);
`else
    assign rounded = sum;
`endif

    // Max of rounded >> LOG2_AVG is 255, so the low byte is exact.
    assign shifted = rounded >> LOG2_AVG;
    assign avg     = shifted[7:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            prev       <= 1'b0;
            acc        <= '0;
            fill       <= '0;
            state      <= S_EMPTY;
            out_valid  <= 1'b0;
            out_data   <= '0;
            overrun    <= 1'b0;
            drop_count <= '0;
        end else if (clear) begin
            // Track the current level so an already-high valid is ignored.
            prev      <= in_valid;
            acc       <= '0;
            fill      <= '0;
            state     <= S_EMPTY;
            out_valid <= 1'b0;
        end else begin
            prev <= in_valid;

            if (complete) begin
                acc  <= '0;
                fill <= '0;
            end else if (capture) begin
                acc  <= sum;
                fill <= fill + FW'(1);
            end

            case (state)
                S_EMPTY: begin
                    if (complete) begin
                        out_data  <= avg;
                        out_valid <= 1'b1;
                        state     <= S_FULL;
                    end
                end
                S_FULL: begin
                    if (complete) begin
                        if (out_ready) begin
                            out_data <= avg;
                        end else begin
                            // Old average is still pending: drop the new one.
                            overrun <= 1'b1;
                            if (drop_count != 8'hFF) begin
                                drop_count <= drop_count + 8'd1;
                            end
                        end
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_EMPTY;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= S_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: doc/sar_result_averager.md
# sar_result_averager

Downstream consumer of the SAR ADC controller's conversion results.
- Detects each new conversion from the controller's `valid` level, which is held for multiple `clk` cycles when strobed by `en`.
- Accumulates 2^LOG2_AVG results and emits their mean through a valid/ready output register.
- Tracks results lost to back-pressure.
- Sits between the SAR controller and the PWM/host consumer.

## Interface
Parameters:
- LOG2_AVG, 2, log2 of samples per average; legal 0..4 (0 = pass-through).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- clear  in  1  synchronous flush of accumulation and output register.
- in_valid  in  1  SAR controller `valid`; a new result is marked by a 0→1 transition.
- in_result  in  8  SAR controller `result`; sampled on the in_valid rising edge.
- out_data  out  8  averaged result.
- out_valid  out  1  out_data holds an unconsumed average.
- out_ready  in  1  consumer accepts out_data when out_valid & out_ready.
- overrun  out  1  sticky; set when a completed average is discarded.
- drop_count  out  8  number of discarded averages, saturates at 255.
- fill  out  LOG2_AVG+1  samples accumulated in the current window.

## Operation
Capture:
- Register `prev` holds the previous in_valid.
- Capture occurs when in_valid & !prev.
- A level held high for any number of cycles counts as exactly one capture.

Accumulation:
- acc has width 8+LOG2_AVG+1.
- On each capture: acc += in_result and fill += 1.

Window completion:
- Completion is a capture with fill == 2^LOG2_AVG − 1.
- sum = acc + in_result.
- avg = sum >> LOG2_AVG, truncating.
- acc and fill return to 0 in the same cycle.

FSM, governing the output register:
- sEmpty → sFull on completion.
- sFull → sEmpty on out_valid & out_ready with no simultaneous completion.
- sFull & completion & out_ready: load the new avg and stay in sFull.
- sFull & completion & !out_ready: discard the new avg, keep the old out_data, set overrun=1, drop_count += 1 (saturating).

Outputs and controls:
- out_valid = (state == sFull).
- out_data is stable while out_valid=1 and out_ready=0.
- clear: acc=0, fill=0, state=sEmpty, and prev <= in_valid, so an already-high valid is not counted.
- clear does not change overrun or drop_count.
- clear takes priority over a capture in the same cycle.
- reset: acc=0, fill=0, prev=0, state=sEmpty, out_data=0, out_valid=0, overrun=0, drop_count=0.
- reset has priority over clear.
- LOG2_AVG=0: every capture is a completion, and out_data equals in_result.

## Timing
- All registers update on posedge clk.
- Completion at edge k (in_valid rising seen at edge k) → out_valid=1 and out_data updated after edge k, i.e. 1 cycle of latency.
- A handshake (out_valid & out_ready high at edge k) deasserts out_valid after edge k, unless a completion occurs at edge k.
- Back-to-back captures are possible on every other cycle, since in_valid must return low for ≥1 cycle; no capture is lost in the accumulator path.
- overrun and drop_count update at the same edge as the discarded completion.

## Configuration
Macro: `SAR_AVG_ROUND_EN`.
- Defined: avg = (sum + 2^(LOG2_AVG−1)) >> LOG2_AVG for LOG2_AVG>0, i.e. round-half-up.
  - Maximum (255·2^N + 2^(N−1)) >> N = 255, so no saturation logic is required.
  - LOG2_AVG=0 is unaffected.
- Undefined: truncating shift only.
- Nothing else differs between the two builds.

## Test plan
- Reset values: assert reset for 2 cycles → all outputs 0, out_valid=0, fill=0.
- Basic average: LOG2_AVG=2, out_ready=1, results 10,20,30,40 each as a 3-cycle in_valid pulse → one out_valid cycle with out_data=25, one cycle after the 4th rising edge; fill returns to 0.
- Rounding: results 1,2,2,2 → out_data=1 with `SAR_AVG_ROUND_EN` undefined, out_data=2 with it defined.
- Held level: in_valid held high for 10 cycles with in_result changing each cycle → exactly one capture (the value at the rising edge); fill=1.
- Back-pressure: out_ready=0, 8 results of 100 → out_data=100 held, overrun=1, drop_count=1.
  - Then out_ready=1 for one cycle → out_valid=0 on the next cycle; overrun stays 1.
- Simultaneous completion and ready: first window gives out_data=50 and out_ready=1 at the same edge as the second window's completion (avg 80) → out_data=80, out_valid stays 1, overrun=0.
- Clear mid-window: 2 captures, then clear while in_valid=1 → fill=0; no capture until in_valid falls and rises again.
